alu_seq_unit: RTL

- Registered, handshaked successor to the combinational logic unit.
- Performs AND/OR/XOR/NOT in one cycle, and SLL/SRL/SRA/ROL iteratively, SHIFT_STEP bit positions per cycle.
- Sits between decode/operand fetch and writeback.
- Uses valid/ready on both sides and holds its result until writeback accepts it.

---
 rtl/simple_processor_pkg.sv | 29 ++
 rtl/alu_shift_step.sv | 39 +++
 rtl/alu_seq_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/simple_processor_pkg.sv
// Shared types and constants for the simple processor datapath units.
package simple_processor_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH);

  // Logic-op encodings are unchanged from the combinational unit; shifts are appended.
  typedef enum logic [3:0] {
    AND = 4'd0,
    OR  = 4'd1,
    XOR = 4'd2,
    NOT = 4'd3,
    SLL = 4'd4,
    SRL = 4'd5,
    SRA = 4'd6,
    ROL = 4'd7
  } func_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(func_t f);
    return (f == SLL) || (f == SRL) || (f == SRA) || (f == ROL);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One partial shift of up to SHIFT_STEP positions for the iterative shifter.
module alu_shift_step
  import simple_processor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHIFT_STEP = 1,
  localparam int unsigned STEP_W    = $clog2(SHIFT_STEP + 1)
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  func_t                 i_func,
  input  logic [STEP_W-1:0]     i_amount,
  input  logic                  i_sign,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [2*DATA_WIDTH-1:0] w_dbl;
  logic [DATA_WIDTH-1:0]   w_ones;
  logic [DATA_WIDTH-1:0]   w_fill;

  // Rotation via a doubled word; sign fill as a mask of the vacated high bits.
  always_comb begin
    w_ones = '1;
    w_dbl  = {i_data, i_data} << i_amount;
    w_fill = ~(w_ones >> i_amount);
  end

  // Select the shift flavour for this step.
  always_comb begin
    o_data = i_data;
    case (i_func)
      SLL:     o_data = i_data << i_amount;
      SRL:     o_data = i_data >> i_amount;
      SRA:     o_data = (i_data >> i_amount) | (i_sign ? w_fill : '0);
      ROL:     o_data = w_dbl[2*DATA_WIDTH-1:DATA_WIDTH];
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Registered, valid/ready logic unit with an iterative multi-cycle shifter.
module alu_seq_unit
  import simple_processor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  func_t                 func_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  zero_o,
  output logic                  illegal_o
);

  localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);
  localparam int unsigned CNT_W   = SHAMT_W + 1;
  localparam int unsigned STEP_W  = $clog2(SHIFT_STEP + 1);

  if (!(SHIFT_STEP >= 1 && SHIFT_STEP <= DATA_WIDTH &&
        (SHIFT_STEP & (SHIFT_STEP - 1)) == 0)) begin : g_bad_step
    $error("alu_seq_unit: SHIFT_STEP must be a power of two in 1..DATA_WIDTH");
  end

  state_t                r_state;
  state_t                w_next_state;
  func_t                 r_func;
  logic                  r_sign;
  logic [DATA_WIDTH-1:0] r_work;
  logic [DATA_WIDTH-1:0] r_result;
  logic [CNT_W-1:0]      r_remaining;
  logic                  r_zero;
  logic                  r_illegal;

  logic                  w_in_ready;
  logic                  w_out_valid;
  logic                  w_accept;
  logic [SHAMT_W-1:0]    w_shamt;
  logic                  w_direct;
  logic [DATA_WIDTH-1:0] w_logic;
  logic                  w_illegal;
  logic [STEP_W-1:0]     w_step;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_shamt  = rs2_data_i[SHAMT_W-1:0];
  // Logic ops, illegal funcs and zero-distance shifts finish in the accept cycle.
  assign w_direct = !(is_shift_op(func_i) && (w_shamt != '0));
  assign w_accept = in_valid_i && w_in_ready;

  // Single-cycle result computed directly from the incoming operands.
  always_comb begin
    w_logic   = '0;
    w_illegal = 1'b0;
    case (func_i)
      AND:               w_logic = rs1_data_i & rs2_data_i;
      OR:                w_logic = rs1_data_i | rs2_data_i;
      XOR:               w_logic = rs1_data_i ^ rs2_data_i;
      NOT:               w_logic = ~rs1_data_i;
      SLL, SRL, SRA, ROL: w_logic = rs1_data_i;
      default:           w_illegal = 1'b1;
    endcase
  end

  // Step size this cycle: min(SHIFT_STEP, remaining).
  always_comb begin
    if (r_remaining < CNT_W'(SHIFT_STEP)) begin
      w_step = STEP_W'(r_remaining);
    end else begin
      w_step = STEP_W'(SHIFT_STEP);
    end
    w_last = (r_remaining == CNT_W'(w_step));
  end

  alu_shift_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift_step (
    .i_data   (r_work),
    .i_func   (r_func),
    .i_amount (w_step),
    .i_sign   (r_sign),
    .o_data   (w_shifted)
  );

  // State register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: DONE can accept a new op on the same edge its result leaves.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = w_direct ? DONE : SHIFT;
      end
      SHIFT: begin
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        if (w_accept)         w_next_state = w_direct ? DONE : SHIFT;
        else if (out_ready_i) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake outputs per state; ready in DONE follows the consumer.
  always_comb begin
    w_in_ready  = 1'b1;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE:  w_in_ready = 1'b1;
      SHIFT: w_in_ready = 1'b0;
      DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = out_ready_i;
      end
      default: w_in_ready = 1'b1;
    endcase
  end

  // Operand capture, iterative shifting and result/flag loading.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_func      <= AND;
      r_sign      <= 1'b0;
      r_work      <= '0;
      r_result    <= '0;
      r_remaining <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      r_func      <= func_i;
      r_sign      <= rs1_data_i[DATA_WIDTH-1];
      r_work      <= rs1_data_i;
      r_remaining <= CNT_W'(w_shamt);
      if (w_direct) begin
        r_result  <= w_logic;
        r_zero    <= (w_logic == '0);
        r_illegal <= w_illegal;
      end
    end else if (r_state == SHIFT) begin
      r_work      <= w_shifted;
      r_remaining <= r_remaining - CNT_W'(w_step);
      if (w_last) begin
        r_result  <= w_shifted;
        r_zero    <= (w_shifted == '0);
        r_illegal <= 1'b0;
      end
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = w_out_valid;
  assign rd_data_o   = r_result;
  assign zero_o      = r_zero;
  assign illegal_o   = r_illegal;

endmodule
